hazard_ctrl: RTL and testbench

//   Pipeline sequencer for the IF/ID/EX/MEM datapath. Generates the stall and flush

---
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: upstream pipeline status in, stall/flush
// controls, watchdog flag and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [4:0]       ex_rd_addr;
  logic             ex_mc_start;
  logic             ex_mc_done;
  logic             ex_redirect;
  logic             mem_wait;

  logic             if_stall;
  logic             id_stall;
  logic             id_flush;
  logic             if_flush;
  logic             ex_stall;
  logic             mem_stall;
  logic             wdog_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // The pipeline side reports status and consumes the controls
  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_mem_read, ex_rd_addr, ex_mc_start, ex_mc_done,
           ex_redirect, mem_wait,
    input  if_stall, id_stall, id_flush, if_flush, ex_stall, mem_stall,
           wdog_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_mem_read, ex_rd_addr, ex_mc_start, ex_mc_done,
           ex_redirect, mem_wait,
    output if_stall, id_stall, id_flush, if_flush, ex_stall, mem_stall,
           wdog_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the IF/ID/EX/MEM pipeline: load-use bubbles, redirect flushes,
// multi-cycle EX freezes and data-memory waits, with watchdog and saturating counters.
module hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int WDOG_MAX         = 64,
  parameter int CNT_W            = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
);

  localparam int         WD_W     = $clog2(WDOG_MAX + 1);
  localparam logic [1:0] BUB_INIT = 2'(REDIRECT_BUBBLES - 1);

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    MC_BUSY,
    MEM_WAIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  state_t            saved;
  state_t            saved_nxt;
  state_t            eff_state;
  logic [1:0]        bub_rem;
  logic [1:0]        bub_nxt;
  logic [WD_W-1:0]   wdog_cnt;
  logic [WD_W-1:0]   wdog_nxt;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              wdog_err_q;
  logic              timeout;
  logic              load_use;
  logic              redirect_take;
  logic              hold;
  logic              if_stall_c;
  logic              id_stall_c;
  logic              id_flush_c;
  logic              if_flush_c;
  logic              ex_stall_c;
  logic              mem_stall_c;

  assign load_use = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd_addr != 5'd0) & hz.id_valid &
                    ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr)) |
                     (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));

  assign timeout = (wdog_cnt >= WD_W'(WDOG_MAX));

  // MEM_WAIT with mem_wait low behaves exactly like the saved state, so the resume is
  // seamless and the saved bubble/busy context continues where it stopped.
  always_comb begin
    eff_state     = (state == MEM_WAIT) ? saved : state;
    state_nxt     = eff_state;
    saved_nxt     = saved;
    bub_nxt       = bub_rem;
    redirect_take = 1'b0;
    hold          = 1'b0;
    if_stall_c    = 1'b0;
    id_stall_c    = 1'b0;
    id_flush_c    = 1'b0;
    if_flush_c    = 1'b0;
    ex_stall_c    = 1'b0;
    mem_stall_c   = 1'b0;

    if (timeout) begin
      state_nxt = RUN;
      saved_nxt = RUN;
      bub_nxt   = 2'd0;
    end else if (hz.mem_wait) begin
      if_stall_c  = 1'b1;
      id_stall_c  = 1'b1;
      ex_stall_c  = 1'b1;
      mem_stall_c = 1'b1;
      hold        = 1'b1;
      state_nxt   = MEM_WAIT;
      if (state != MEM_WAIT) saved_nxt = state;
    end else begin
      case (eff_state)
        MC_BUSY: begin
          if (hz.ex_mc_done) begin
            state_nxt = RUN;
          end else begin
            if_stall_c = 1'b1;
            id_stall_c = 1'b1;
            ex_stall_c = 1'b1;
            hold       = 1'b1;
          end
        end
        REDIRECT: begin
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
          bub_nxt    = bub_rem - 2'd1;
          if (bub_rem <= 2'd1) state_nxt = RUN;
        end
        default: begin
          if (hz.ex_mc_start) begin
            if_stall_c = 1'b1;
            id_stall_c = 1'b1;
            ex_stall_c = 1'b1;
            hold       = 1'b1;
            state_nxt  = MC_BUSY;
          end else if (hz.ex_redirect) begin
            if_flush_c    = 1'b1;
            id_flush_c    = 1'b1;
            redirect_take = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
              state_nxt = REDIRECT;
              bub_nxt   = BUB_INIT;
            end
          end else if (load_use) begin
            if_stall_c = 1'b1;
            id_stall_c = 1'b1;
            id_flush_c = 1'b1;
          end
        end
      endcase
    end

    if (timeout) wdog_nxt = '0;
    else if (hold) wdog_nxt = wdog_cnt + WD_W'(1);
    else wdog_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      saved       <= RUN;
      bub_rem     <= 2'd0;
      wdog_cnt    <= '0;
      wdog_err_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state      <= state_nxt;
      saved      <= saved_nxt;
      bub_rem    <= bub_nxt;
      wdog_cnt   <= wdog_nxt;
      wdog_err_q <= wdog_err_q | timeout;
      if (if_stall_c && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_take && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Controls are forced low while reset is held, even with live upstream inputs
  assign hz.if_stall  = reset_n & if_stall_c;
  assign hz.id_stall  = reset_n & id_stall_c;
  assign hz.id_flush  = reset_n & id_flush_c;
  assign hz.if_flush  = reset_n & if_flush_c;
  assign hz.ex_stall  = reset_n & ex_stall_c;
  assign hz.mem_stall = reset_n & mem_stall_c;
  assign hz.wdog_err  = wdog_err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle corner
// sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;

  localparam int RB   = 2;
  localparam int WD   = 64;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset_n;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(
    .REDIRECT_BUBBLES(RB),
    .WDOG_MAX(WD),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: {if_stall, id_stall, id_flush, if_flush, ex_stall, mem_stall}
  typedef struct {
    logic       ex_valid;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       redir;
    logic       mc_start;
    logic       mem_wait;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  int checks = 0;
  int errors = 0;
  logic [5:0] last_vec;

  int m_bub;
  bit m_mc;
  int m_hold;
  bit m_err;
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dutVec();
    return {hz.if_stall, hz.id_stall, hz.id_flush, hz.if_flush, hz.ex_stall, hz.mem_stall};
  endfunction

  task automatic setIdle();
    hz.id_valid    = 1'b0;
    hz.id_rs1_addr = 5'd0;
    hz.id_rs2_addr = 5'd0;
    hz.id_uses_rs1 = 1'b0;
    hz.id_uses_rs2 = 1'b0;
    hz.ex_valid    = 1'b0;
    hz.ex_mem_read = 1'b0;
    hz.ex_rd_addr  = 5'd0;
    hz.ex_mc_start = 1'b0;
    hz.ex_mc_done  = 1'b0;
    hz.ex_redirect = 1'b0;
    hz.mem_wait    = 1'b0;
  endtask

  task automatic modelReset();
    m_bub       = 0;
    m_mc        = 1'b0;
    m_hold      = 0;
    m_err       = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Reference: a timeout wins, mem_wait freezes everything, then a pending
  // multi-cycle op, then leftover redirect bubbles, then new events from RUN.
  task automatic modelStep(output logic [5:0] e);
    bit lu;
    lu = hz.ex_valid && hz.ex_mem_read && (hz.ex_rd_addr != 0) && hz.id_valid &&
         ((hz.id_uses_rs1 && hz.id_rs1_addr == hz.ex_rd_addr) ||
          (hz.id_uses_rs2 && hz.id_rs2_addr == hz.ex_rd_addr));
    e = 6'b000000;
    if (m_hold >= WD) begin
      m_err  = 1'b1;
      m_mc   = 1'b0;
      m_bub  = 0;
      m_hold = 0;
    end else if (hz.mem_wait) begin
      e = 6'b110011;
      m_hold++;
    end else if (m_mc) begin
      if (hz.ex_mc_done) begin
        m_mc   = 1'b0;
        m_hold = 0;
      end else begin
        e = 6'b110010;
        m_hold++;
      end
    end else if (m_bub > 0) begin
      e = 6'b001100;
      m_bub--;
      m_hold = 0;
    end else if (hz.ex_mc_start) begin
      e = 6'b110010;
      m_mc = 1'b1;
      m_hold++;
    end else if (hz.ex_redirect) begin
      e = 6'b001100;
      if (m_flush_cnt < CMAX) m_flush_cnt++;
      m_bub  = RB - 1;
      m_hold = 0;
    end else begin
      if (lu) e = 6'b111000;
      m_hold = 0;
    end
    if (e[5] && m_stall_cnt < CMAX) m_stall_cnt++;
  endtask

  task automatic tick();
    logic [5:0] e;
    @(negedge clk);
    checkOutput("stall_cnt", int'(hz.stall_cnt), m_stall_cnt);
    checkOutput("flush_cnt", int'(hz.flush_cnt), m_flush_cnt);
    checkOutput("wdog_err", int'(hz.wdog_err), int'(m_err));
    modelStep(e);
    last_vec = dutVec();
    checkOutput("ctrl_vec", int'(last_vec), int'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    setIdle();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    setIdle();
    hz.ex_valid    = v.ex_valid;
    hz.ex_mem_read = v.ex_mem_read;
    hz.ex_rd_addr  = v.ex_rd;
    hz.id_valid    = v.id_valid;
    hz.id_rs1_addr = v.rs1;
    hz.id_rs2_addr = v.rs2;
    hz.id_uses_rs1 = v.u1;
    hz.id_uses_rs2 = v.u2;
    hz.ex_redirect = v.redir;
    hz.ex_mc_start = v.mc_start;
    hz.mem_wait    = v.mem_wait;
  endtask

  task automatic loadUseInputs();
    hz.ex_valid    = 1'b1;
    hz.ex_mem_read = 1'b1;
    hz.ex_rd_addr  = 5'd5;
    hz.id_valid    = 1'b1;
    hz.id_rs1_addr = 5'd5;
    hz.id_rs2_addr = 5'd1;
    hz.id_uses_rs1 = 1'b1;
    hz.id_uses_rs2 = 1'b1;
  endtask

  initial begin
    int ex_cycles;
    int mem_cycles;
    reset_n = 1'b0;
    setIdle();
    modelReset();

    //           ev mr rd     iv rs1    rs2    u1 u2 rd mc mw  exp
    vecs[0]  = '{0, 0, 5'd0,  0, 5'd0,  5'd0,  0, 0, 0, 0, 0, 6'b000000};
    vecs[1]  = '{1, 1, 5'd5,  1, 5'd5,  5'd1,  1, 1, 0, 0, 0, 6'b111000};
    vecs[2]  = '{1, 1, 5'd7,  1, 5'd2,  5'd7,  1, 1, 0, 0, 0, 6'b111000};
    vecs[3]  = '{1, 1, 5'd7,  1, 5'd2,  5'd7,  1, 0, 0, 0, 0, 6'b000000};
    vecs[4]  = '{1, 1, 5'd0,  1, 5'd0,  5'd3,  1, 1, 0, 0, 0, 6'b000000};
    vecs[5]  = '{1, 1, 5'd5,  0, 5'd5,  5'd5,  1, 1, 0, 0, 0, 6'b000000};
    vecs[6]  = '{1, 0, 5'd5,  1, 5'd5,  5'd5,  1, 1, 0, 0, 0, 6'b000000};
    vecs[7]  = '{1, 1, 5'd5,  1, 5'd5,  5'd1,  1, 1, 1, 0, 0, 6'b001100};
    vecs[8]  = '{1, 1, 5'd5,  1, 5'd5,  5'd1,  1, 1, 1, 1, 0, 6'b110010};
    vecs[9]  = '{1, 1, 5'd5,  1, 5'd5,  5'd1,  1, 1, 1, 1, 1, 6'b110011};
    vecs[10] = '{0, 1, 5'd9,  1, 5'd9,  5'd9,  1, 1, 0, 0, 0, 6'b000000};

    doReset();
    checkOutput("reset_vec", int'(dutVec()), 0);
    checkOutput("reset_stall_cnt", int'(hz.stall_cnt), 0);

    for (int i = 0; i < 11; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("table%0d", i), int'(last_vec), int'(vecs[i].exp));
      checkOutput($sformatf("table%0d_stall_cnt", i), int'(hz.stall_cnt), int'(vecs[i].exp[5]));
    end

    // Load-use bubble then the pipeline inserts the bubble in EX
    doReset();
    loadUseInputs();
    tick();
    checkOutput("lu_vec", int'(last_vec), 6'b111000);
    setIdle();
    tick();
    checkOutput("lu_release", int'(last_vec), 0);
    checkOutput("lu_stall_cnt", int'(hz.stall_cnt), 1);

    // Two-bubble redirect with a concurrent load-use that must stay masked
    doReset();
    loadUseInputs();
    hz.ex_redirect = 1'b1;
    tick();
    checkOutput("redir_b1", int'(last_vec), 6'b001100);
    tick();
    checkOutput("redir_b2", int'(last_vec), 6'b001100);
    setIdle();
    tick();
    checkOutput("redir_done", int'(last_vec), 0);
    checkOutput("redir_flush_cnt", int'(hz.flush_cnt), 1);
    checkOutput("redir_stall_cnt", int'(hz.stall_cnt), 0);

    // Multi-cycle op finishing five cycles after start
    doReset();
    ex_cycles  = 0;
    mem_cycles = 0;
    hz.ex_mc_start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) hz.ex_mc_done = 1'b1;
      tick();
      hz.ex_mc_start = 1'b0;
      if (last_vec[1]) ex_cycles++;
      if (last_vec[0]) mem_cycles++;
    end
    checkOutput("mc_done_vec", int'(last_vec), 0);
    checkOutput("mc_ex_cycles", ex_cycles, 5);
    checkOutput("mc_mem_cycles", mem_cycles, 0);

    // mem_wait during the first of two redirect bubbles
    doReset();
    hz.ex_redirect = 1'b1;
    tick();
    hz.ex_redirect = 1'b0;
    hz.mem_wait    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("mw_stall%0d", c), int'(last_vec), 6'b110011);
    end
    hz.mem_wait = 1'b0;
    tick();
    checkOutput("mw_resume_flush", int'(last_vec), 6'b001100);
    tick();
    checkOutput("mw_after", int'(last_vec), 0);
    checkOutput("mw_flush_cnt", int'(hz.flush_cnt), 1);

    // Watchdog: ex_mc_done never arrives
    doReset();
    hz.ex_mc_start = 1'b1;
    tick();
    hz.ex_mc_start = 1'b0;
    for (int c = 1; c < WD; c++) tick();
    checkOutput("wd_last_stall", int'(last_vec), 6'b110010);
    checkOutput("wd_err_before", int'(hz.wdog_err), 0);
    tick();
    checkOutput("wd_timeout_vec", int'(last_vec), 0);
    checkOutput("wd_err", int'(hz.wdog_err), 1);
    loadUseInputs();
    tick();
    checkOutput("wd_run_lu", int'(last_vec), 6'b111000);
    checkOutput("wd_err_sticky", int'(hz.wdog_err), 1);

    // Asynchronous reset in the middle of a multi-cycle op
    setIdle();
    hz.ex_mc_start = 1'b1;
    tick();
    hz.ex_mc_start = 1'b0;
    tick();
    loadUseInputs();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_vec", int'(dutVec()), 0);
    checkOutput("arst_stall_cnt", int'(hz.stall_cnt), 0);
    checkOutput("arst_flush_cnt", int'(hz.flush_cnt), 0);
    checkOutput("arst_wdog_err", int'(hz.wdog_err), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
    setIdle();
    tick();
    checkOutput("arst_run", int'(last_vec), 0);

    // Randomized traffic against the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      hz.ex_valid    = ($urandom_range(99) < 70);
      hz.ex_mem_read = ($urandom_range(99) < 50);
      hz.ex_rd_addr  = 5'($urandom_range(3));
      hz.id_valid    = ($urandom_range(99) < 80);
      hz.id_rs1_addr = 5'($urandom_range(3));
      hz.id_rs2_addr = 5'($urandom_range(3));
      hz.id_uses_rs1 = ($urandom_range(99) < 60);
      hz.id_uses_rs2 = ($urandom_range(99) < 40);
      hz.ex_mc_start = ($urandom_range(99) < 5);
      hz.ex_mc_done  = ($urandom_range(99) < 20);
      hz.ex_redirect = ($urandom_range(99) < 10);
      hz.mem_wait    = ($urandom_range(99) < 10);
      tick();
    end
    setIdle();
    tick();
    checkOutput("rand_stall_sat", int'(hz.stall_cnt), CMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
